// File: rtl/preproc_sfifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : preproc_sfifo_pkg
// Description : Shared constants and types for the pre-processing staging
//               FIFO: default geometry and read-mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package preproc_sfifo_pkg;

  // Width of one real or imaginary input sample component.
  localparam int c_fft_in_width       = 16;

  // Default entry width: one packed I/Q sample.
  localparam int c_preproc_data_width = 2 * c_fft_in_width;

  // Default log2 of depth (8 entries, matching the buffer this replaces).
  localparam int c_preproc_addr_width = 3;

  // Read-mode encodings for the FWFT parameter.
  localparam int c_preproc_fifo_fwft  = 1;
  localparam int c_preproc_fifo_reg   = 0;

  typedef enum logic {
    FIFO_MODE_REG  = 1'b0,
    FIFO_MODE_FWFT = 1'b1
  } fifo_mode_e;

  // Map the integer FWFT parameter onto the mode enum.
  function automatic fifo_mode_e fifo_mode(input int fwft);
    return (fwft == c_preproc_fifo_fwft) ? FIFO_MODE_FWFT : FIFO_MODE_REG;
  endfunction

endpackage : preproc_sfifo_pkg
`default_nettype wire

// File: rtl/preproc_sfifo_if.sv
`default_nettype none
// ============================================================================
// Module      : preproc_sfifo_if
// Description : Bus bundle for the staging FIFO. The master side is the
//               producer/consumer logic; the slave side is the FIFO itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface preproc_sfifo_if
  import preproc_sfifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_preproc_data_width,
  parameter int ADDR_WIDTH = c_preproc_addr_width
);

  logic                  clr_i;
  logic                  we_i;
  logic [DATA_WIDTH-1:0] din_i;
  logic                  re_i;
  logic [ADDR_WIDTH:0]   af_thresh_i;
  logic [ADDR_WIDTH:0]   ae_thresh_i;
  logic [DATA_WIDTH-1:0] dout_o;
  logic                  dout_vld_o;
  logic [ADDR_WIDTH:0]   level_o;
  logic                  full_o;
  logic                  empty_o;
  logic                  almost_full_o;
  logic                  almost_empty_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output clr_i, we_i, din_i, re_i, af_thresh_i, ae_thresh_i,
    input  dout_o, dout_vld_o, level_o, full_o, empty_o,
           almost_full_o, almost_empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  clr_i, we_i, din_i, re_i, af_thresh_i, ae_thresh_i,
    output dout_o, dout_vld_o, level_o, full_o, empty_o,
           almost_full_o, almost_empty_o, overflow_o, underflow_o
  );

endinterface : preproc_sfifo_if
`default_nettype wire

// File: rtl/preproc_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : preproc_fifo_ram
// Description : DEPTH x DATA_WIDTH register array, one synchronous write
//               port and one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module preproc_fifo_ram
  import preproc_sfifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_preproc_data_width,
  parameter int ADDR_WIDTH = c_preproc_addr_width
) (
  input  logic                  clk_sys,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int c_depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_depth];

  // Store the incoming entry on an accepted write.
  always_ff @(posedge clk_sys) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule : preproc_fifo_ram
`default_nettype wire

// File: rtl/preproc_sfifo.sv
`default_nettype none
// ============================================================================
// Module      : preproc_sfifo
// Description : Parametrised synchronous FIFO staging samples between the
//               input interface and the DFT datapath. Show-ahead or
//               registered read, occupancy count, run-time almost-full/empty
//               thresholds and sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module preproc_sfifo
  import preproc_sfifo_pkg::*;
#(
  parameter int DATA_WIDTH = c_preproc_data_width,
  parameter int ADDR_WIDTH = c_preproc_addr_width,
  parameter int FWFT       = c_preproc_fifo_fwft
) (
  input  logic            clk_sys,
  input  logic            rst_sys_n,
  preproc_sfifo_if.slave  fifo_bus
);

  localparam fifo_mode_e          c_mode      = fifo_mode(FWFT);
  localparam logic [ADDR_WIDTH:0] c_depth_lvl = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] c_one       = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_rd_en;
  logic                  w_wr_en;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Full/empty come from the occupancy counter, so a wrapped pointer pair
  // never needs to be disambiguated.
  assign w_full  = (r_level == c_depth_lvl);
  assign w_empty = (r_level == '0);

  // A read is only ever served from stored data; a write into a full FIFO
  // is allowed when a read frees a slot in the same cycle.
  assign w_rd_ok = fifo_bus.re_i && !w_empty;
  assign w_wr_ok = fifo_bus.we_i && (!w_full || w_rd_ok);

  // Clear overrides both requests.
  assign w_rd_en = w_rd_ok && !fifo_bus.clr_i;
  assign w_wr_en = w_wr_ok && !fifo_bus.clr_i;

  preproc_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_sys (clk_sys),
    .i_we    (w_wr_en),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (fifo_bus.din_i),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rdata)
  );

  // Advance pointers and track occupancy on accepted transfers.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else if (fifo_bus.clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_en) begin
        r_wptr <= r_wptr + c_one;
      end
      if (w_rd_en) begin
        r_rptr <= r_rptr + c_one;
      end
      if (w_wr_en && !w_rd_en) begin
        r_level <= r_level + c_one;
      end else if (w_rd_en && !w_wr_en) begin
        r_level <= r_level - c_one;
      end
    end
  end

  // Latch refused requests until cleared.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (fifo_bus.clr_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (fifo_bus.we_i && !w_wr_ok) begin
        r_overflow <= 1'b1;
      end
      if (fifo_bus.re_i && !w_rd_ok) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign fifo_bus.level_o        = r_level;
  assign fifo_bus.full_o         = w_full;
  assign fifo_bus.empty_o        = w_empty;
  assign fifo_bus.almost_full_o  = (r_level >= fifo_bus.af_thresh_i);
  assign fifo_bus.almost_empty_o = (r_level <= fifo_bus.ae_thresh_i);
  assign fifo_bus.overflow_o     = r_overflow;
  assign fifo_bus.underflow_o    = r_underflow;

  generate
    if (c_mode == FIFO_MODE_FWFT) begin : g_fwft
      // Head entry is visible directly; forced to zero when empty so the
      // output never exposes an unwritten memory location.
      assign fifo_bus.dout_o     = w_empty ? '0 : w_rdata;
      assign fifo_bus.dout_vld_o = !w_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] r_dout;
      logic                  r_dout_vld;

      // Capture the head entry on an accepted read; hold it otherwise.
      always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
          r_dout     <= '0;
          r_dout_vld <= 1'b0;
        end else if (fifo_bus.clr_i) begin
          r_dout_vld <= 1'b0;
        end else begin
          r_dout_vld <= w_rd_en;
          if (w_rd_en) begin
            r_dout <= w_rdata;
          end
        end
      end

      assign fifo_bus.dout_o     = r_dout;
      assign fifo_bus.dout_vld_o = r_dout_vld;
    end
  endgenerate

endmodule : preproc_sfifo
`default_nettype wire

// File: tb/tb_preproc_sfifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_preproc_sfifo
// Description : Directed, table-driven bench for the staging FIFO. One
//               show-ahead instance runs a vector table; one registered-read
//               instance and an asynchronous reset are covered by short
//               hand-written sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_preproc_sfifo;
  import preproc_sfifo_pkg::*;

  localparam int c_dw = 8;
  localparam int c_aw = 3;

  typedef struct {
    logic       clr;
    logic       we;
    logic       re;
    logic [7:0] din;
    logic [3:0] af;
    logic [3:0] ae;
    logic [3:0] lvl;
    logic       full;
    logic       empty;
    logic       afl;
    logic       ael;
    logic       ovf;
    logic       udf;
    logic [7:0] dout;
  } vec_t;

  logic clk_sys   = 1'b0;
  logic rst_sys_n = 1'b0;
  int   n_vec     = 0;
  int   n_err     = 0;
  vec_t vecs[$];

  preproc_sfifo_if #(.DATA_WIDTH(c_dw), .ADDR_WIDTH(c_aw)) bus_f ();
  preproc_sfifo_if #(.DATA_WIDTH(c_dw), .ADDR_WIDTH(c_aw)) bus_r ();

  preproc_sfifo #(
    .DATA_WIDTH (c_dw),
    .ADDR_WIDTH (c_aw),
    .FWFT       (c_preproc_fifo_fwft)
  ) u_dut_fwft (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .fifo_bus  (bus_f)
  );

  preproc_sfifo #(
    .DATA_WIDTH (c_dw),
    .ADDR_WIDTH (c_aw),
    .FWFT       (c_preproc_fifo_reg)
  ) u_dut_reg (
    .clk_sys   (clk_sys),
    .rst_sys_n (rst_sys_n),
    .fifo_bus  (bus_r)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic av(input logic clr, input logic we, input logic re, input logic [7:0] din,
                    input logic [3:0] af, input logic [3:0] ae, input logic [3:0] lvl,
                    input logic full, input logic empty, input logic afl, input logic ael,
                    input logic ovf, input logic udf, input logic [7:0] dout);
    vec_t v;
    v.clr = clr; v.we = we; v.re = re; v.din = din; v.af = af; v.ae = ae;
    v.lvl = lvl; v.full = full; v.empty = empty; v.afl = afl; v.ael = ael;
    v.ovf = ovf; v.udf = udf; v.dout = dout;
    vecs.push_back(v);
  endtask

  // {level, full, empty, almost_full, almost_empty, overflow, underflow, dout}
  function automatic logic [31:0] pack_f();
    return {14'd0, bus_f.level_o, bus_f.full_o, bus_f.empty_o, bus_f.almost_full_o,
            bus_f.almost_empty_o, bus_f.overflow_o, bus_f.underflow_o, bus_f.dout_o};
  endfunction

  function automatic logic [31:0] pack_v(input vec_t v);
    return {14'd0, v.lvl, v.full, v.empty, v.afl, v.ael, v.ovf, v.udf, v.dout};
  endfunction

  // {level, underflow, dout_vld, dout}
  function automatic logic [31:0] pack_r();
    return {18'd0, bus_r.level_o, bus_r.underflow_o, bus_r.dout_vld_o, bus_r.dout_o};
  endfunction

  task automatic drive_r(input logic clr, input logic we, input logic re, input logic [7:0] din);
    @(negedge clk_sys);
    bus_r.clr_i = clr; bus_r.we_i = we; bus_r.re_i = re; bus_r.din_i = din;
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    bus_f.clr_i = 0; bus_f.we_i = 0; bus_f.re_i = 0; bus_f.din_i = '0;
    bus_f.af_thresh_i = 4'd6; bus_f.ae_thresh_i = 4'd2;
    bus_r.clr_i = 0; bus_r.we_i = 0; bus_r.re_i = 0; bus_r.din_i = '0;
    bus_r.af_thresh_i = 4'd6; bus_r.ae_thresh_i = 4'd2;

    // ---------------- vector table (show-ahead instance) ----------------
    // Boundary: af threshold 0 makes almost_full true even when empty.
    av(0,0,0,8'h00, 0,2, 0, 0,1,1,1, 0,0, 8'h00);
    // Fill 0x01..0x08; head stays at 0x01.
    for (int i = 1; i <= 8; i++)
      av(0,1,0,8'(i), 6,2, 4'(i), (i == 8), 0, (i >= 6), (i <= 2), 0,0, 8'h01);
    // Write into full: dropped, overflow latches.
    av(0,1,0,8'h09, 6,2, 8, 1,0,1,0, 1,0, 8'h01);
    // Drain: head walks 0x02..0x08, then zero when empty.
    for (int k = 1; k <= 8; k++)
      av(0,0,1,8'h00, 6,2, 4'(8-k), 0, (k == 8), ((8-k) >= 6), ((8-k) <= 2), 1,0,
         (k == 8) ? 8'h00 : 8'(k+1));
    // Read when empty: underflow latches.
    av(0,0,1,8'h00, 6,2, 0, 0,1,0,1, 1,1, 8'h00);
    // Clear with simultaneous requests: requests ignored, flags cleared.
    av(1,1,1,8'h77, 6,2, 0, 0,1,0,1, 0,0, 8'h00);
    // Read+write when empty: write taken, read refused.
    av(0,1,1,8'h55, 6,2, 1, 0,0,0,1, 0,1, 8'h55);
    av(1,0,0,8'h00, 6,2, 0, 0,1,0,1, 0,0, 8'h00);
    // Refill with 0x10..0x17.
    for (int i = 0; i < 8; i++)
      av(0,1,0,8'(16+i), 6,2, 4'(i+1), (i == 7), 0, ((i+1) >= 6), ((i+1) <= 2), 0,0, 8'h10);
    // Read+write at full: level holds, no overflow, head advances.
    av(0,1,1,8'hAA, 6,2, 8, 1,0,1,0, 0,0, 8'h11);
    // Drain across the pointer wrap; 0xAA comes out last.
    for (int k = 1; k <= 8; k++)
      av(0,0,1,8'h00, 6,2, 4'(8-k), 0, (k == 8), ((8-k) >= 6), ((8-k) <= 2), 0,0,
         (k == 8) ? 8'h00 : ((k == 7) ? 8'hAA : 8'(17+k)));

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk_sys);
    #1;
    chk("reset_fwft", pack_f(), {14'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    chk("reset_reg",  pack_r(), {18'd0, 4'd0, 1'b0, 1'b0, 8'h00});
    @(negedge clk_sys);
    rst_sys_n = 1'b1;

    // ---------------- apply table ----------------
    foreach (vecs[idx]) begin
      @(negedge clk_sys);
      bus_f.clr_i = vecs[idx].clr; bus_f.we_i = vecs[idx].we; bus_f.re_i = vecs[idx].re;
      bus_f.din_i = vecs[idx].din;
      bus_f.af_thresh_i = vecs[idx].af; bus_f.ae_thresh_i = vecs[idx].ae;
      @(posedge clk_sys);
      #1;
      chk($sformatf("vec%0d", idx), pack_f(), pack_v(vecs[idx]));
    end
    @(negedge clk_sys);
    bus_f.clr_i = 0; bus_f.we_i = 0; bus_f.re_i = 0;

    // ---------------- registered-read instance ----------------
    drive_r(0,1,0,8'h11);
    chk("reg_wr1", pack_r(), {18'd0, 4'd1, 1'b0, 1'b0, 8'h00});
    drive_r(0,1,0,8'h22);
    chk("reg_wr2", pack_r(), {18'd0, 4'd2, 1'b0, 1'b0, 8'h00});
    drive_r(0,0,1,8'h00);
    chk("reg_rd1", pack_r(), {18'd0, 4'd1, 1'b0, 1'b1, 8'h11});
    drive_r(0,0,1,8'h00);
    chk("reg_rd2", pack_r(), {18'd0, 4'd0, 1'b0, 1'b1, 8'h22});
    drive_r(0,0,0,8'h00);
    chk("reg_hold", pack_r(), {18'd0, 4'd0, 1'b0, 1'b0, 8'h22});
    drive_r(0,0,1,8'h00);
    chk("reg_udf", pack_r(), {18'd0, 4'd0, 1'b1, 1'b0, 8'h22});
    drive_r(1,0,0,8'h00);
    chk("reg_clr", pack_r(), {18'd0, 4'd0, 1'b0, 1'b0, 8'h22});
    drive_r(0,0,0,8'h00);

    // ---------------- asynchronous reset mid-burst ----------------
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      bus_f.we_i = 1; bus_f.din_i = 8'(8'h30 + i);
      bus_r.we_i = 1; bus_r.din_i = 8'(8'h40 + i);
      @(posedge clk_sys);
    end
    #2;
    chk("burst_lvl", {28'd0, bus_f.level_o}, 32'd3);
    rst_sys_n = 1'b0;
    #1;
    chk("async_rst_fwft", pack_f(), {14'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    chk("async_rst_reg",  pack_r(), {18'd0, 4'd0, 1'b0, 1'b0, 8'h00});
    @(negedge clk_sys);
    bus_f.we_i = 0; bus_r.we_i = 0;
    rst_sys_n = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("post_rst_fwft", pack_f(), {14'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_preproc_sfifo
`default_nettype wire
